// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes, marks frame
// boundaries and errors. Define MII_RX_FCS_CHECK_EN to include the CRC-32 FCS check.
module mii_rx_framer #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MIN_FRAME_BYTES = 64
) (
  input  logic        enet_rx_clk,
  input  logic        i_reset,
  input  logic        i_rx_dv,
  input  logic [3:0]  i_rx_data,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_err,
  output logic [15:0] o_frame_len,
  output logic [15:0] o_frames_ok,
  output logic [15:0] o_frames_bad
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state_q;
  logic        phase_q;
  logic [3:0]  lo_q;
  logic [7:0]  hold_q;
  logic [15:0] len_q;
  logic        first_q;
  logic        crc_bad;
  logic        len_err;

  assign len_err = len_q < 16'(MIN_FRAME_BYTES);

`ifdef MII_RX_FCS_CHECK_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Running CRC over the whole frame including FCS lands on the fixed residue.
  assign crc_bad = crc_q != 32'hDEBB20E3;

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) crc_q <= 32'hFFFFFFFF;
    else if (state_q == PREAMBLE) crc_q <= 32'hFFFFFFFF;
    else if (state_q == DATA && i_rx_dv && phase_q) crc_q <= crc_byte(crc_q, {i_rx_data, lo_q});
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      lo_q         <= 4'd0;
      hold_q       <= 8'd0;
      len_q        <= 16'd0;
      first_q      <= 1'b1;
      o_data       <= 8'd0;
      o_valid      <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_err        <= 1'b0;
      o_frame_len  <= 16'd0;
      o_frames_ok  <= 16'd0;
      o_frames_bad <= 16'd0;
    end else begin
      first_q <= 1'b0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      o_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          // dv already high right out of reset means we joined mid-frame
          if (i_rx_dv) state_q <= (!first_q && i_rx_data == 4'h5) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!i_rx_dv) state_q <= IDLE;
          else if (i_rx_data == 4'hD) begin
            state_q <= DATA;
            phase_q <= 1'b0;
            len_q   <= 16'd0;
          end else if (i_rx_data != 4'h5) state_q <= DROP;
        end
        DATA: begin
          if (!i_rx_dv) begin
            state_q <= IDLE;
            if (len_q != 16'd0) begin
              o_valid     <= 1'b1;
              o_data      <= hold_q;
              o_sof       <= len_q == 16'd1;
              o_eof       <= 1'b1;
              o_err       <= phase_q | len_err | crc_bad;
              o_frame_len <= len_q;
              if (phase_q | len_err | crc_bad) o_frames_bad <= o_frames_bad + 16'd1;
              else                             o_frames_ok  <= o_frames_ok + 16'd1;
            end else begin
              o_frames_bad <= o_frames_bad + 16'd1;
            end
          end else if (!phase_q) begin
            lo_q    <= i_rx_data;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            len_q   <= len_q + 16'd1;
            hold_q  <= {i_rx_data, lo_q};
            if (len_q != 16'd0) begin
              o_valid <= 1'b1;
              o_data  <= hold_q;
              o_sof   <= len_q == 16'd1;
            end
            if (len_q == 16'(MAX_FRAME_BYTES)) begin
              o_eof        <= 1'b1;
              o_err        <= 1'b1;
              o_frame_len  <= 16'(MAX_FRAME_BYTES);
              o_frames_bad <= o_frames_bad + 16'd1;
              state_q      <= DROP;
            end
          end
        end
        DROP: if (!i_rx_dv) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
